// File: rtl/booth_mul_arbiter.sv
// Sequential radix-2 Booth multiplier shared by two requesters through a round-robin arbiter.
// One add/subtract-and-shift step per clock; the product is returned tagged with the requester ID.
module booth_mul_arbiter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [WIDTH-1:0]     req0_m,
    input  logic [WIDTH-1:0]     req0_q,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [WIDTH-1:0]     req1_m,
    input  logic [WIDTH-1:0]     req1_q,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [2*WIDTH-1:0]   rsp_mul,
    output logic                 busy
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;

    state_e               state_q, state_d;
    logic                 last_q, last_d;
    logic                 id_q, id_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [WIDTH:0]       a_q, a_d;
    logic [WIDTH-1:0]     qr_q, qr_d;
    logic                 q1_q, q1_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   mul_q, mul_d;

    logic                 gnt0, gnt1;
    logic [WIDTH:0]       m_ext, sum;

    // On a tie the requester not granted last wins.
    always_comb begin
        gnt1       = req1_valid && (!req0_valid || !last_q);
        gnt0       = req0_valid && !gnt1;
        req0_ready = (state_q == StIdle) && !rst && gnt0;
        req1_ready = (state_q == StIdle) && !rst && gnt1;
    end

    // A is one bit wider than m so that m = -2^(WIDTH-1) cannot overflow mid-step.
    always_comb begin
        m_ext = {m_q[WIDTH-1], m_q};
        case ({qr_q[0], q1_q})
            2'b01:   sum = a_q + m_ext;
            2'b10:   sum = a_q - m_ext;
            default: sum = a_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        m_d     = m_q;
        a_d     = a_q;
        qr_d    = qr_q;
        q1_d    = q1_q;
        cnt_d   = cnt_q;
        mul_d   = mul_q;
        case (state_q)
            StIdle: begin
                if (req0_ready || req1_ready) begin
                    id_d    = gnt1;
                    last_d  = gnt1;
                    m_d     = gnt1 ? req1_m : req0_m;
                    qr_d    = gnt1 ? req1_q : req0_q;
                    a_d     = '0;
                    q1_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = StIter;
                end
            end
            StIter: begin
                a_d   = {sum[WIDTH], sum[WIDTH:1]};
                qr_d  = {sum[0], qr_q[WIDTH-1:1]};
                q1_d  = qr_q[0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    // Low 2*WIDTH bits of the shifted {A, Q}.
                    mul_d   = {sum, qr_q[WIDTH-1:1]};
                    state_d = StDone;
                end
            end
            StDone: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            m_q     <= '0;
            a_q     <= '0;
            qr_q    <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            mul_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            m_q     <= m_d;
            a_q     <= a_d;
            qr_q    <= qr_d;
            q1_q    <= q1_d;
            cnt_q   <= cnt_d;
            mul_q   <= mul_d;
        end
    end

    assign rsp_valid = (state_q == StDone);
    assign rsp_id    = id_q;
    assign rsp_mul   = mul_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Self-checking bench for booth_mul_arbiter: cycle-level reference model plus directed vectors.
module tb_booth_mul_arbiter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [3:0]   req0_m, req0_q, req1_m, req1_q;
    logic         rsp_valid, rsp_ready, rsp_id, busy;
    logic [7:0]   rsp_mul;

    int checks = 0;
    int errors = 0;

    booth_mul_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_m     (req0_m),
        .req0_q     (req0_q),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_m     (req1_m),
        .req1_q     (req1_q),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_mul    (rsp_mul),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [7:0] smul(logic [3:0] m, logic [3:0] q);
        int p;
        p = int'($signed(m)) * int'($signed(q));
        return p[7:0];
    endfunction

    // Reference model: mdl_age counts cycles since acceptance (0 = idle, W+1 = response).
    int         mdl_age   = 0;
    logic       mdl_last  = 1'b1;
    logic       mdl_init  = 1'b0;
    logic       mdl_fresh = 1'b0;
    logic [7:0] mdl_mul   = 8'h00;
    logic       mdl_id    = 1'b0;
    logic [7:0] pend_mul  = 8'h00;
    logic       pend_id   = 1'b0;
    logic       e_r0, e_r1;

    always_comb begin
        e_r0 = (mdl_age == 0) && !rst && req0_valid && (!req1_valid || mdl_last);
        e_r1 = (mdl_age == 0) && !rst && req1_valid && (!req0_valid || !mdl_last);
    end

    always @(posedge clk) begin
        if (rst) begin
            mdl_age   <= 0;
            mdl_last  <= 1'b1;
            mdl_mul   <= 8'h00;
            mdl_id    <= 1'b0;
            mdl_init  <= 1'b1;
            mdl_fresh <= 1'b1;
        end else if (mdl_age == 0) begin
            if (e_r0 || e_r1) begin
                mdl_age   <= 1;
                mdl_last  <= e_r1;
                pend_mul  <= e_r1 ? smul(req1_m, req1_q) : smul(req0_m, req0_q);
                pend_id   <= e_r1;
                mdl_fresh <= 1'b0;
            end
        end else if (mdl_age <= W) begin
            mdl_age <= mdl_age + 1;
            if (mdl_age == W) begin
                mdl_mul <= pend_mul;
                mdl_id  <= pend_id;
            end
        end else if (rsp_ready) begin
            mdl_age <= 0;
        end
    end

    always @(negedge clk) begin
        if (mdl_init) begin
            chk("req0_ready", req0_ready, e_r0);
            chk("req1_ready", req1_ready, e_r1);
            chk("busy", busy, mdl_age != 0);
            chk("rsp_valid", rsp_valid, mdl_age == W + 1);
            if (mdl_age == W + 1 || mdl_fresh) begin
                chk("model_rsp_mul", rsp_mul, mdl_mul);
                chk("model_rsp_id", rsp_id, mdl_id);
            end
        end
    end

    task automatic issue(input int r, input logic [3:0] m, input logic [3:0] q);
        bit done = 1'b0;
        if (r == 0) begin
            req0_m = m; req0_q = q; req0_valid = 1'b1;
        end else begin
            req1_m = m; req1_q = q; req1_valid = 1'b1;
        end
        for (int k = 0; k < 30 && !done; k++) begin
            @(negedge clk);
            if ((r == 0) ? req0_ready : req1_ready) done = 1'b1;
            @(posedge clk); #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout req%0d: got no ready, required ready within 30 cycles", r);
        end
    endtask

    task automatic collect(input logic [7:0] exp, input logic eid, input int stall,
                           output int lat);
        bit seen = 1'b0;
        lat = 0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) seen = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: got no rsp_valid, required product %0h", exp);
            @(posedge clk); #1;
            return;
        end
        chk("rsp_mul", rsp_mul, exp);
        chk("rsp_id", rsp_id, eid);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("bp_valid", rsp_valid, 1);
            chk("bp_mul", rsp_mul, exp);
            chk("bp_id", rsp_id, eid);
            chk("bp_readys", {req0_ready, req1_ready}, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        if (stall > 0) begin
            @(negedge clk);
            chk("bp_release", {busy, rsp_valid}, 0);
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish before 500000");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [7:0] v;
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b0; rsp_ready = 1'b0;
        req0_m = 4'h1; req0_q = 4'h1; req1_m = 4'h0; req1_q = 4'h0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset_ready0", req0_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        req0_valid = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {rsp_valid, rsp_id, busy, rsp_mul}, 0);
        @(posedge clk); #1;

        // Single request: 3 * -2
        issue(0, 4'h3, 4'hE);
        collect(8'hFA, 1'b0, 0, lat);
        chk("latency", lat, 5);

        // Corner operands on requester 1
        issue(1, 4'h8, 4'h8); collect(8'h40, 1'b1, 0, lat);
        issue(1, 4'h8, 4'h7); collect(8'hC8, 1'b1, 0, lat);
        issue(1, 4'h7, 4'h7); collect(8'h31, 1'b1, 0, lat);
        issue(1, 4'h0, 4'h5); collect(8'h00, 1'b1, 0, lat);

        // Tie after reset, then both held valid: grants alternate
        do_reset();
        req0_m = 4'h2; req0_q = 4'h3; req1_m = 4'hC; req1_q = 4'h5;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int t = 0; t < 6; t++) begin
            if (t % 2 == 0) collect(8'h06, 1'b0, 0, lat);
            else            collect(8'hEC, 1'b1, 0, lat);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Back-pressure: 7 * -3 held for 3 cycles
        issue(0, 4'h7, 4'hD);
        collect(8'hEB, 1'b0, 3, lat);

        // Reset during step 2 of 5 * 3
        issue(0, 4'h5, 4'h3);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("iter_reset_outputs", {rsp_valid, rsp_id, busy, rsp_mul, req0_ready, req1_ready}, 0);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("aborted_no_rsp", rsp_valid, 0);
        end
        @(posedge clk); #1;
        issue(1, 4'h5, 4'h3);
        collect(8'h0F, 1'b1, 0, lat);

        // Exhaustive sweep, alternating requesters
        for (int i = 0; i < 256; i++) begin
            v = i[7:0];
            issue(i % 2, v[7:4], v[3:0]);
            collect(smul(v[7:4], v[3:0]), 1'(i % 2), 0, lat);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
